// File: rtl/serial_addsub.sv
// serial_addsub -- bit-serial two's-complement adder/subtractor.
//
// A single full-adder slice plus a carry flip-flop processes one operand bit
// per clock, LSB first. This is the small, slow counterpart to a parallel
// ripple adder. A controller drives it through start/done.
//
// Optional feature macro: SERIAL_ADDSUB_ZERO_FLAG_EN
//   When defined, this adds output port `zero`. It is 1 when the final result
//   is 0 and is registered together with `result`. The bit is built serially
//   by OR-ing the sum bits as they are produced.
//
// Ports
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      request; accepted only in IDLE or DONE
//   sub     in   1      0 = a+b, 1 = a-b; latched on accept
//   a, b    in   WIDTH  operands; latched on accept
//   busy    out  1      high while in RUN (WIDTH cycles)
//   done    out  1      one-cycle pulse; result/cout/ovf valid
//   result  out  WIDTH  sum/difference, held until the next done
//   cout    out  1      final carry (sub: 1 = no borrow)
//   ovf     out  1      signed overflow
//   zero    out  1      result == 0 (only with SERIAL_ADDSUB_ZERO_FLAG_EN)
//
// Handshake: start is a level request. It is taken on any rising edge where
// the FSM is in IDLE or DONE. That includes the DONE cycle, so operations can
// run back to back. In RUN, start is ignored. The FSM state is visible for
// debug as r_state.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_sha;
  logic [WIDTH-1:0] r_shb;
  logic [WIDTH-1:0] r_shr;
  logic             r_carry;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic             w_sum;
  logic             w_carry_nxt;

  assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last      = (r_count == CW'(WIDTH - 1));
  assign w_sum       = r_sha[0] ^ r_shb[0] ^ r_carry;
  assign w_carry_nxt = (r_sha[0] & r_shb[0]) | (r_sha[0] & r_carry) | (r_shb[0] & r_carry);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs follow the state directly
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
  logic r_zacc;
  logic r_zero;
  assign zero = r_zero;
`endif

  // Datapath. Subtraction is a + ~b + 1, so the +1 is the carry seed. The
  // result registers load only on the last RUN edge. Mid-operation they keep
  // the previous answer, and the partial sum stays in r_shr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sha    <= '0;
      r_shb    <= '0;
      r_shr    <= '0;
      r_carry  <= 1'b0;
      r_count  <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
      r_zacc   <= 1'b0;
      r_zero   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_sha   <= a;
      r_shb   <= sub ? ~b : b;
      r_carry <= sub;
      r_count <= '0;
      r_shr   <= '0;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
      r_zacc  <= 1'b0;
`endif
    end else if (r_state == S_RUN) begin
      r_carry <= w_carry_nxt;
      r_sha   <= r_sha >> 1;
      r_shb   <= r_shb >> 1;
      r_shr   <= {w_sum, r_shr[WIDTH-1:1]};
      r_count <= r_count + CW'(1);
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
      r_zacc  <= r_zacc | w_sum;
`endif
      if (w_last) begin
        r_result <= {w_sum, r_shr[WIDTH-1:1]};
        r_cout   <= w_carry_nxt;
        // r_carry is the carry into the MSB during the last slice
        r_ovf    <= r_carry ^ w_carry_nxt;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        r_zero   <= ~(r_zacc | w_sum);
`endif
      end
    end
  end

  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;

endmodule
